dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MIPS core's load/store port. It accepts one word, halfword or byte request at a time over a valid/ready handshake and inserts a configurable number of wait states. Sub-word stores are done as read-modify-write on a synchronous-read word array. Load data is returned right-justified and zero-filled, so the datapath's existing byte/half sign- and zero-extension muxes apply unchanged.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words in the array; address range 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 1: extra access latency in cycles, legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted at an edge where req_valid && req_ready.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse; completes the accepted request.
- resp_data  out  32  load data, right-justified, upper bits zero; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; request rejected and no array access made.

## Operation
- Little-endian lanes: byte k = addr[1:0] occupies bits [8k+7:8k]; half at addr[1] occupies [16*addr[1]+15 : 16*addr[1]]. Word index = addr[31:2].
- Request fields are captured into registers at acceptance. Inputs are ignored while outside IDLE.
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE: on accept, either go to RESP with an error flag, or go to ACCESS with cnt = WAIT_CYCLES.
- ACCESS: while cnt != 0, decrement cnt. At the edge where cnt == 0:
  - Load: the array word is read into rdata_q; go to RESP.
  - Word store: the array is written; go to RESP.
  - Byte or half store: the array word is read into rdata_q; go to MERGE.
- MERGE: the captured lane of wdata is merged into rdata_q and the merged word is written at this edge; go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, with resp_data/resp_err; then IDLE.
- Error conditions (when the checks are enabled): size == 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[31:2] >= DEPTH. On error there is no read and no write; resp_data = 0 and resp_err = 1.
- There is no response backpressure. The requester must sample resp_valid every cycle.
- Array contents are not cleared by reset and are undefined after power-up.

## Timing
- Acceptance edge = E0. Load and word-store response cycle begins at edge E(WAIT_CYCLES+1). Byte/half store response begins at E(WAIT_CYCLES+2). Error response begins at E1.
- req_ready returns high in the cycle after the RESP cycle. The earliest next accept is at the edge ending that cycle.
- Reset values, with reset low at an edge: state IDLE, cnt 0, resp_valid 0, resp_data 0, resp_err 0, rdata_q 0. req_ready is 1 in the cycle after reset.
- Reset mid-operation: the transaction is abandoned and no response is issued. Any write not yet performed at that edge is dropped; a write on the same edge as reset is also suppressed.
- Store followed by a load to the same word always returns the stored or merged value. This holds because requests are serialised.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: all error conditions above are checked and reported via resp_err.
- Undefined:
  - resp_err is tied 0.
  - Low address bits are ignored where they would cause a misalignment: word accesses use addr[1:0] = 00, half accesses use addr[0] = 0.
  - size 11 is treated as word.
  - The word index wraps modulo DEPTH.
  - The error path, including the E1 response, does not exist.

## Test plan
DEPTH = 64, WAIT_CYCLES = 1 unless noted.
1. sw addr 0x08 wdata 0xDEADBEEF, then lw 0x08 -> resp_data 0xDEADBEEF, resp_err 0. Each resp_valid is exactly one cycle, beginning at E2 after accept. req_ready is low from accept until after RESP.
2. sb addr 0x09 wdata 0xFFFFFFAA -> store response at E3. Then lw 0x08 -> 0xDEADAAEF; lbu/lb 0x09 -> resp_data 0x000000AA.
3. sh addr 0x0A wdata 0x00001234 -> lw 0x08 returns 0x1234AAEF; lh 0x0A returns 0x00001234.
4. With DMEM_ALIGN_CHECK_EN: lw 0x06 -> resp_err 1, resp_data 0 at E1, memory unchanged. lw 0x100 -> resp_err 1. Without the macro: lw 0x06 returns word 0x04, and lw 0x100 returns word 0x00.
5. Sweep WAIT_CYCLES in {0, 3, 15} -> load latency is WAIT_CYCLES+1 edges and sub-word store latency is WAIT_CYCLES+2 edges. Back-to-back requests with req_valid held high are accepted one per transaction, with no lost or duplicated responses.
6. Start sw 0x10 wdata 0x11111111 over prior 0x0; pull reset low during ACCESS -> no resp_valid, req_ready high after reset. A subsequent lw 0x10 returns 0x00000000.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the MIPS datapath (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, we, size, addr, wdata,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, we, size, addr, wdata,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one byte/half/word access at a time, WAIT_CYCLES wait states,
// sub-word stores by read-modify-write. Define DMEM_ALIGN_CHECK_EN to report misaligned/out-of-range requests.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [1:0]  size_n;
  logic [31:0] addr_n;
  logic        req_err;
  logic [AW-1:0] idx;
  logic [31:0] merged;
  logic        mem_we;
  logic [31:0] mem_wd;

  // Request normalisation at acceptance: either flag the error or fold it away.
  always_comb begin
    size_n  = bus.size;
    addr_n  = bus.addr;
    req_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    req_err = (bus.size == 2'b11) ||
              (bus.size == 2'b01 && bus.addr[0]) ||
              (bus.size == 2'b10 && bus.addr[1:0] != 2'b00) ||
              (bus.addr[31:2] >= 30'(DEPTH));
`else
    if (bus.size == 2'b11) size_n = 2'b10;
    if (size_n == 2'b10) addr_n[1:0] = 2'b00;
    if (size_n == 2'b01) addr_n[0] = 1'b0;
`endif
  end

  assign idx = AW'(addr_q[31:2] % 30'(DEPTH));

  function automatic logic [31:0] lane_rd(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off);
    case (sz)
      2'b00:   return {24'h0, w[{off, 3'b000} +: 8]};
      2'b01:   return {16'h0, w[{off[1], 4'b0000} +: 16]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    merged = rdata_q;
    if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  assign mem_we = (state == ACCESS && cnt == 4'd0 && !err_q && we_q && size_q == 2'b10) ||
                  (state == MERGE);
  assign mem_wd = (state == MERGE) ? merged : wdata_q;

  // Array is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            we_q      <= bus.we;
            size_q    <= size_n;
            addr_q    <= addr_n;
            wdata_q   <= bus.wdata;
            err_q     <= req_err;
            // Errors pass through ACCESS once so their response lands one edge after accept.
            cnt       <= req_err ? 4'd0 : 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (err_q) begin
            resp_valid <= 1'b1;
            resp_data  <= 32'h0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else if (!we_q) begin
            rdata_q    <= mem[idx];
            resp_data  <= lane_rd(mem[idx], size_q, addr_q[1:0]);
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if (size_q == 2'b10) begin
            resp_data  <= 32'h0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else begin
            rdata_q <= mem[idx];
            state   <= MERGE;
          end
        end
        MERGE: begin
          resp_data  <= 32'h0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_data  <= 32'h0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.resp_err   = resp_err;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT per wait-state setting (1, 0, 3, 15),
// hand-computed load/store results, latencies, back-to-back and mid-transaction reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rv [4];
  logic        wr [4];
  logic [1:0]  sz [4];
  logic [31:0] ad [4];
  logic [31:0] wd [4];
  logic        rdy [4];
  logic        vld [4];
  logic        er  [4];
  logic [31:0] rd  [4];

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
    dmem_responder_if bus();
    assign bus.req_valid = rv[g];
    assign bus.we        = wr[g];
    assign bus.size      = sz[g];
    assign bus.addr      = ad[g];
    assign bus.wdata     = wd[g];
    assign rdy[g]        = bus.req_ready;
    assign vld[g]        = bus.resp_valid;
    assign er[g]         = bus.resp_err;
    assign rd[g]         = bus.resp_data;
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  end

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic xact(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] wdat, output logic [31:0] data, output logic err,
                      output int lat);
    int n;
    @(negedge clk);
    rv[d] = 1'b1; wr[d] = w; sz[d] = s; ad[d] = a; wd[d] = wdat;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(rdy[d]), 1);
    @(posedge clk); #1;
    rv[d] = 1'b0;
    chk("busy_after_accept", 32'(rdy[d]), 0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (vld[d]) break;
    end
    chk("resp_seen", 32'(vld[d]), 1);
    data = rd[d];
    err  = er[d];
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(vld[d]), 0);
    chk("ready_after_resp", 32'(rdy[d]), 1);
  endtask

  task automatic op(input string tag, input int d, input logic w, input logic [1:0] s,
                    input logic [31:0] a, input logic [31:0] wdat, input logic [31:0] exp_data,
                    input logic exp_err, input int exp_lat);
    logic [31:0] data;
    logic        err;
    int          lat;
    xact(d, w, s, a, wdat, data, err, lat);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int acc, rsp, bad, seen, wc;
    for (int i = 0; i < 4; i++) begin
      rv[i] = 0; wr[i] = 0; sz[i] = 0; ad[i] = 0; wd[i] = 0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 1);
    chk("rst_valid", 32'(vld[0]), 0);
    chk("rst_data", rd[0], 0);
    chk("rst_err", 32'(er[0]), 0);

    // word store/load, then byte and half read-modify-write
    op("sw08", 0, 1, 2'b10, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2);
    op("lw08", 0, 0, 2'b10, 32'h08, 32'h0, 32'hDEADBEEF, 0, 2);
    op("sb09", 0, 1, 2'b00, 32'h09, 32'hFFFFFFAA, 32'h0, 0, 3);
    op("lw08_b", 0, 0, 2'b10, 32'h08, 32'h0, 32'hDEADAAEF, 0, 2);
    op("lb09", 0, 0, 2'b00, 32'h09, 32'h0, 32'h000000AA, 0, 2);
    op("sh0a", 0, 1, 2'b01, 32'h0A, 32'h00001234, 32'h0, 0, 3);
    op("lw08_h", 0, 0, 2'b10, 32'h08, 32'h0, 32'h1234AAEF, 0, 2);
    op("lh0a", 0, 0, 2'b01, 32'h0A, 32'h0, 32'h00001234, 0, 2);
    op("lb0b", 0, 0, 2'b00, 32'h0B, 32'h0, 32'h00000012, 0, 2);
    op("lh08", 0, 0, 2'b01, 32'h08, 32'h0, 32'h0000AAEF, 0, 2);

    // misaligned / out-of-range handling
    op("sw04", 0, 1, 2'b10, 32'h04, 32'hCAFEF00D, 32'h0, 0, 2);
    op("sw00", 0, 1, 2'b10, 32'h00, 32'h01234567, 32'h0, 0, 2);
`ifdef DMEM_ALIGN_CHECK_EN
    op("lw06_err", 0, 0, 2'b10, 32'h06, 32'h0, 32'h0, 1, 1);
    op("lw100_err", 0, 0, 2'b10, 32'h100, 32'h0, 32'h0, 1, 1);
    op("sz11_err", 0, 1, 2'b11, 32'h04, 32'hFFFFFFFF, 32'h0, 1, 1);
    op("lw04_kept", 0, 0, 2'b10, 32'h04, 32'h0, 32'hCAFEF00D, 0, 2);
`else
    op("lw06_fold", 0, 0, 2'b10, 32'h06, 32'h0, 32'hCAFEF00D, 0, 2);
    op("lw100_wrap", 0, 0, 2'b10, 32'h100, 32'h0, 32'h01234567, 0, 2);
    op("lh05_fold", 0, 0, 2'b01, 32'h05, 32'h0, 32'h0000F00D, 0, 2);
    op("sz11_word", 0, 0, 2'b11, 32'h0A, 32'h0, 32'h1234AAEF, 0, 2);
`endif

    // wait-state sweep on the other three instances
    for (int d = 1; d < 4; d++) begin
      wc = (d == 1) ? 0 : (d == 2) ? 3 : 15;
      op($sformatf("sw20_w%0d", wc), d, 1, 2'b10, 32'h20, 32'h5A5A5A5A, 32'h0, 0, wc + 1);
      op($sformatf("sb21_w%0d", wc), d, 1, 2'b00, 32'h21, 32'h000000C3, 32'h0, 0, wc + 2);
      op($sformatf("lw20_w%0d", wc), d, 0, 2'b10, 32'h20, 32'h0, 32'h5A5AC35A, 0, wc + 1);
      op($sformatf("lh22_w%0d", wc), d, 0, 2'b01, 32'h22, 32'h0, 32'h00005A5A, 0, wc + 1);
    end

    // back-to-back loads with req_valid held high: one accept every 4 edges
    acc = 0; rsp = 0; bad = 0;
    @(negedge clk);
    rv[0] = 1; wr[0] = 0; sz[0] = 2'b10; ad[0] = 32'h08;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (rdy[0]) acc++;
      if (vld[0]) begin rsp++; if (rd[0] !== 32'h1234AAEF) bad++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rv[0] = 0;
      if (vld[0]) begin rsp++; if (rd[0] !== 32'h1234AAEF) bad++; end
    end
    chk("b2b_accepts", 32'(acc), 8);
    chk("b2b_responses", 32'(rsp), 32'(acc));
    chk("b2b_bad_data", 32'(bad), 0);

    // reset on the edge the word store would have been written
    op("sw10_zero", 0, 1, 2'b10, 32'h10, 32'h0, 32'h0, 0, 2);
    @(negedge clk);
    rv[0] = 1; wr[0] = 1; sz[0] = 2'b10; ad[0] = 32'h10; wd[0] = 32'h11111111;
    @(posedge clk); #1;
    rv[0] = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(vld[0]), 0);
    chk("midrst_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vld[0]) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 0);
    op("lw10_after_rst", 0, 0, 2'b10, 32'h10, 32'h0, 32'h00000000, 0, 2);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
